// File: rtl/sample_buffer.sv
// Sample request FSM and first-word-fall-through FIFO between the sine reader
// and the codec. Keeps the output stream pre-filled, one request in flight at most.
module sample_buffer #(
    parameter int DEPTH_LOG2 = 3,
    parameter int WIDTH      = 16,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    output logic                  generate_next,
    input  logic                  sample_ready,
    input  logic [WIDTH-1:0]      sample,
    output logic [WIDTH-1:0]      out_sample,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DEPTH_LOG2:0]   fill_level,
    output logic                  timeout_err,
    output logic                  spurious_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        wait_cnt_q, wait_cnt_d;
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]     count_q, count_d;
    logic [WIDTH-1:0]        mem_q [DEPTH];
    logic [WIDTH-1:0]        mem_d [DEPTH];
    logic                    timeout_err_q, timeout_err_d;
    logic                    spurious_err_q, spurious_err_d;
    logic                    push;
    logic                    pop;

    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        mem_d          = mem_q;
        timeout_err_d  = timeout_err_q;
        spurious_err_d = spurious_err_q;
        push           = 1'b0;
        pop            = (count_q != '0) && out_ready;

        case (state_q)
            IDLE: begin
                if (enable && (count_q < (DEPTH_LOG2 + 1)'(DEPTH)))
                    state_d = REQ;
            end
            REQ: begin
                state_d    = WAIT;
                wait_cnt_d = '0;
            end
            WAIT: begin
                if (sample_ready) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A response outside WAIT has no matching request; drop the data.
        if (sample_ready && (state_q != WAIT))
            spurious_err_d = 1'b1;

        if (push) begin
            mem_d[wr_ptr_q] = sample;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + 1'b1;

        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            wait_cnt_q     <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            timeout_err_q  <= 1'b0;
            spurious_err_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            timeout_err_q  <= timeout_err_d;
            spurious_err_q <= spurious_err_d;
            mem_q          <= mem_d;
        end
    end

    assign generate_next = (state_q == REQ);
    assign out_valid     = (count_q != '0);
    assign out_sample    = out_valid ? mem_q[rd_ptr_q] : '0;
    assign fill_level    = count_q;
    assign timeout_err   = timeout_err_q;
    assign spurious_err  = spurious_err_q;

endmodule
